uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
Sequences the byte stream produced by the UART receiver into validated command frames of the form SYNC, LEN, PAYLOAD[LEN], CSUM. Hunts for the sync byte, bounds the length, buffers the payload, and checks the checksum. Only a good frame is released downstream, on a valid/ready byte stream. Sits between the UART receiver and the command decoder.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame (1..255); sets buffer depth.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYCLES, 43400, idle clocks allowed between bytes inside a frame (about 10 byte times at 115200 baud on a 50 MHz clock).

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
byte_in  in  8  byte from the UART receiver
byte_valid  in  1  one-cycle strobe; byte_in is valid in this cycle
out_data  out  8  payload byte of a validated frame
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data when out_valid and out_ready are both high
out_last  out  1  high with the final payload byte
frame_ok  out  1  one-cycle pulse when the checksum passes
err_csum  out  1  one-cycle pulse on checksum mismatch
err_len  out  1  one-cycle pulse when LEN > MAX_LEN
err_timeout  out  1  one-cycle pulse on inter-byte timeout
err_overrun  out  1  one-cycle pulse when a byte arrives while draining
busy  out  1  high in any state except HUNT

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state = HUNT; all outputs 0; sum, index, length and timer registers cleared. Reset mid-frame or mid-drain discards the frame with no error pulse.
- State machine:
  - HUNT: a byte_valid with byte_in == SYNC_BYTE moves to LEN. Any other byte is ignored.
  - LEN: on byte_valid, latch len = byte_in and set sum = byte_in.
    - len > MAX_LEN: pulse err_len, go to HUNT.
    - len == 0: go to CSUM.
    - Otherwise: go to PAYLOAD with idx = 0.
  - PAYLOAD: on byte_valid, buf[idx] = byte_in, sum += byte_in (mod 256), idx++. After the byte where idx == len-1, go to CSUM.
  - CSUM: on byte_valid, check (sum + byte_in) mod 256 == 0.
    - Pass: pulse frame_ok. Go to DRAIN with rd = 0 if len > 0, otherwise go to HUNT.
    - Fail: pulse err_csum, go to HUNT.
  - DRAIN: out_valid = 1, out_data = buf[rd], out_last = (rd == len-1). On out_ready, rd++. After the last byte is accepted, go to HUNT.
- Pulse timing: every pulse is registered and asserts on the clock edge after the triggering byte_valid cycle.
- Output stability: out_valid rises the cycle after the CSUM byte. out_data and out_last are held stable while out_valid is high and out_ready is low.
- Timeout:
  - Applies in LEN, PAYLOAD and CSUM.
  - The timer clears on entry to the state and on every byte_valid, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 with no byte_valid, pulse err_timeout and go to HUNT.
  - If byte_valid arrives in the same cycle as expiry, the byte wins and no timeout occurs.
  - No timeout applies in HUNT or DRAIN.
- Overrun: a byte_valid in DRAIN pulses err_overrun and the byte is dropped. The drain continues unaffected, and the dropped byte is not treated as a sync byte.
- At most one error pulse per cycle. Only frame_ok and err_* pulse; no pulses while in HUNT except on reset-free ignore (none).
- Arithmetic: sum is 8 bits and wraps. idx and rd are $clog2(MAX_LEN+1) bits wide. len compares at a full 8 bits.

Decomposition:
- Package uart_pkg:
  - state enum {HUNT, LEN, PAYLOAD, CSUM, DRAIN}, 3-bit logic;
  - default SYNC_BYTE constant;
  - clock/baud constants (CLK_HZ 50000000, BAUD 115200, derived clocks-per-bit).
- Sub-module uart_frame_buf: MAX_LEN x 8 register array, synchronous write (we, waddr, wdata), combinational read (raddr -> rdata), no reset on contents.

Test Plan:
- Good frame: bytes A5 03 11 22 33 97 -> frame_ok pulse; then out_data 11, 22, 33 with out_last only on 33; out_ready held 1 gives 3 consecutive cycles; busy low afterwards.
- Bad checksum: A5 03 11 22 33 98 -> err_csum pulse, out_valid never asserts; a following good frame is accepted normally.
- Length limits:
  - A5 11 (17 > MAX_LEN 16) -> err_len, return to HUNT;
  - A5 00 00 -> frame_ok, no out_valid;
  - A5 10 + 16 bytes + correct checksum -> 16 bytes drained.
- Noise and timeout:
  - 00 FF 5A A5 02 AA 55 FF -> only the A5-led frame is accepted, draining AA then 55;
  - A5 02 11 followed by silence -> err_timeout exactly TIMEOUT_CYCLES clocks after the 11 strobe;
  - a byte on the expiry cycle suppresses the timeout.
- Backpressure/overrun: good 3-byte frame with out_ready=0 for 20 cycles and a byte_valid (A5) during DRAIN -> err_overrun pulse, out_data stays 11, A5 not treated as sync; release out_ready -> 11 22 33 drained.
- Reset: assert rst for 1 cycle mid-PAYLOAD and mid-DRAIN -> all outputs 0 next cycle, busy 0, no error pulse, next frame parsed correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive framing path.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  localparam int CLK_HZ       = 50_000_000;
  localparam int BAUD         = 115_200;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  // Ten 10-bit byte times of silence before a partial frame is abandoned.
  localparam int DEFAULT_TIMEOUT_CYCLES = 100 * CLKS_PER_BIT;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: synchronous write, combinational read, contents never reset.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Turns the UART byte stream into checksum-validated SYNC/LEN/PAYLOAD/CSUM frames
// and releases the payload of good frames on a valid/ready byte stream.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       err_csum,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic       busy,
  output state_t     dbg_state
);

  localparam int AW = $clog2(MAX_LEN + 1);
  localparam int BW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    MAX_LEN_B  = 8'(MAX_LEN);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [7:0]    len;
  logic [7:0]    sum;
  logic [AW-1:0] idx;
  logic [AW-1:0] rd;
  logic [TW-1:0] timer;

  logic [7:0] fb_rdata;
  logic [7:0] csum_total;
  logic       fb_we;
  logic       idx_last;
  logic       rd_last;
  logic       timer_expired;

  assign csum_total    = sum + byte_in;
  assign idx_last      = (9'(idx) + 9'd1) == {1'b0, len};
  assign rd_last       = (9'(rd) + 9'd1) == {1'b0, len};
  assign timer_expired = (timer == TIMER_LAST);
  assign fb_we         = (state == PAYLOAD) && byte_valid;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (BW)
  ) u_frame_buf (
    .clk   (clk),
    .we    (fb_we),
    .waddr (idx[BW-1:0]),
    .wdata (byte_in),
    .raddr (rd[BW-1:0]),
    .rdata (fb_rdata)
  );

  // Output handshake: a byte transfers on any rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready low, out_data
  // and out_last hold, since rd only moves on a transfer and the buffer is not
  // written outside PAYLOAD.
  assign out_data  = out_valid ? fb_rdata : 8'd0;
  assign out_last  = out_valid && rd_last;
  assign busy      = (state != HUNT);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      len         <= 8'd0;
      sum         <= 8'd0;
      idx         <= '0;
      rd          <= '0;
      timer       <= '0;
      out_valid   <= 1'b0;
      frame_ok    <= 1'b0;
      err_csum    <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      frame_ok    <= 1'b0;
      err_csum    <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;

      case (state)
        HUNT: begin
          if (byte_valid && byte_in == SYNC_BYTE) begin
            state <= LEN;
            timer <= '0;
          end
        end

        LEN: begin
          if (byte_valid) begin
            len   <= byte_in;
            sum   <= byte_in;
            idx   <= '0;
            timer <= '0;
            if (byte_in > MAX_LEN_B) begin
              err_len <= 1'b1;
              state   <= HUNT;
            end else if (byte_in == 8'd0) begin
              state <= CSUM;
            end else begin
              state <= PAYLOAD;
            end
          end else if (timer_expired) begin
            err_timeout <= 1'b1;
            state       <= HUNT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        PAYLOAD: begin
          if (byte_valid) begin
            sum   <= sum + byte_in;
            idx   <= idx + 1'b1;
            timer <= '0;
            if (idx_last) state <= CSUM;
          end else if (timer_expired) begin
            err_timeout <= 1'b1;
            state       <= HUNT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        CSUM: begin
          if (byte_valid) begin
            timer <= '0;
            if (csum_total == 8'd0) begin
              frame_ok <= 1'b1;
              if (len != 8'd0) begin
                state     <= DRAIN;
                rd        <= '0;
                out_valid <= 1'b1;
              end else begin
                state <= HUNT;
              end
            end else begin
              err_csum <= 1'b1;
              state    <= HUNT;
            end
          end else if (timer_expired) begin
            err_timeout <= 1'b1;
            state       <= HUNT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DRAIN: begin
          // Bytes arriving here are dropped outright, sync bytes included.
          if (byte_valid) err_overrun <= 1'b1;
          if (out_ready) begin
            if (rd_last) begin
              out_valid <= 1'b0;
              state     <= HUNT;
            end else begin
              rd <= rd + 1'b1;
            end
          end
        end

        default: begin
          state     <= HUNT;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: frame-level reference model plus directed
// timing, backpressure, overrun and reset sequences.
module tb_uart_rx_frame_ctrl;
  import uart_pkg::*;

  localparam int         MAX_LEN = 16;
  localparam int         T       = 64;
  localparam logic [7:0] SYNC    = 8'hA5;

  localparam logic [7:0] EV_OK   = 8'd1;
  localparam logic [7:0] EV_CSUM = 8'd2;
  localparam logic [7:0] EV_LEN  = 8'd3;
  localparam logic [7:0] EV_TMO  = 8'd4;
  localparam logic [7:0] EV_OVR  = 8'd5;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok, err_csum, err_len, err_timeout, err_overrun, busy;
  state_t     dbg_state;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .MAX_LEN        (MAX_LEN),
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .frame_ok    (frame_ok),
    .err_csum    (err_csum),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ready_mode = 1;  // 0 random, 1 always ready, 2 never ready

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];   // {last, data}
  logic [7:0] exp_ev[$];
  int         acc_cyc[$];
  logic [8:0] prev_word = 9'd0;
  bit         prev_stall = 1'b0;

  always @(negedge clk) begin : monitor
    int         npulse;
    logic [7:0] ev;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      npulse = int'(frame_ok) + int'(err_csum) + int'(err_len) + int'(err_timeout) + int'(err_overrun);
      if (npulse != 0) begin
        check("one_pulse", npulse, 1);
        ev = frame_ok ? EV_OK : err_csum ? EV_CSUM : err_len ? EV_LEN : err_timeout ? EV_TMO : EV_OVR;
        if (exp_ev.size() == 0) check("unexpected_event", ev, 0);
        else                    check("event", ev, exp_ev.pop_front());
      end
      if (prev_stall) check("hold", {out_valid, out_last, out_data}, {1'b1, prev_word});
      if (out_valid && out_ready) begin
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_data", 1, 0);
        else                   check("data", {out_last, out_data}, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] s_b[$];  // stream bytes
  int         s_g[$];  // idle cycles before each byte

  // Frame-level parse of the whole stream: a gap of T or more idle cycles
  // before an in-frame byte abandons the frame, and that byte is re-hunted.
  task automatic model_stream();
    int n, i, k, len_v;
    logic [7:0] total;
    n = s_b.size();
    i = 0;
    while (i < n) begin
      if (s_b[i] != SYNC) begin
        i++;
        continue;
      end
      if (i + 1 >= n || s_g[i + 1] >= T) begin
        exp_ev.push_back(EV_TMO);
        i++;
        continue;
      end
      len_v = int'(s_b[i + 1]);
      if (len_v > MAX_LEN) begin
        exp_ev.push_back(EV_LEN);
        i += 2;
        continue;
      end
      k = -1;
      for (int j = i + 2; j <= i + 2 + len_v; j++) begin
        if (j >= n || s_g[j] >= T) begin
          k = j;
          break;
        end
      end
      if (k >= 0) begin
        exp_ev.push_back(EV_TMO);
        i = k;
        continue;
      end
      total = 8'(len_v);
      for (int j = 0; j <= len_v; j++) total = total + s_b[i + 2 + j];
      if (total == 8'd0) begin
        exp_ev.push_back(EV_OK);
        for (int j = 0; j < len_v; j++) exp_q.push_back({j == len_v - 1, s_b[i + 2 + j]});
      end else begin
        exp_ev.push_back(EV_CSUM);
      end
      i += 3 + len_v;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add(input logic [7:0] b, input int g);
    s_b.push_back(b);
    s_g.push_back(g);
  endtask

  function automatic int rand_gap();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return T - 1;
    if (r == 1) return T;
    return int'($urandom_range(0, 2));
  endfunction

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    byte_valid = 1'b1;
    byte_in    = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  // Plays s_b/s_g, holding back while a frame drains so no byte overruns.
  task automatic run_stream();
    int guard;
    model_stream();
    for (int i = 0; i < s_b.size(); i++) begin
      repeat (s_g[i]) begin
        @(posedge clk); #1;
        byte_valid = 1'b0;
      end
      @(posedge clk); #1;
      guard = 0;
      while (out_valid && guard < 5000) begin
        byte_valid = 1'b0;
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 5000) check("drive_wait", out_valid, 0);
      byte_valid = 1'b1;
      byte_in    = s_b[i];
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    repeat (T + 4) @(posedge clk);
    guard = 0;
    while ((out_valid || exp_q.size() != 0) && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    check("stream_idle", out_valid, 0);
    check("events_left", exp_ev.size(), 0);
    check("data_left", exp_q.size(), 0);
    exp_ev.delete();
    exp_q.delete();
    s_b.delete();
    s_g.delete();
  endtask

  task automatic gen_random(input int nfr);
    int         kind, len_v, cut, g0;
    bit         force_gap;
    logic [7:0] sum, cs;
    logic [7:0] fb[$];
    force_gap = 1'b0;
    s_b.delete();
    s_g.delete();
    repeat (nfr) begin
      kind = int'($urandom_range(0, 9));
      g0 = force_gap ? T + int'($urandom_range(0, 3)) : rand_gap();
      force_gap = 1'b0;
      if (kind == 7) begin
        repeat ($urandom_range(1, 3)) begin
          add(8'($urandom_range(0, 255)), g0);
          g0 = rand_gap();
        end
      end else if (kind == 6) begin
        add(SYNC, g0);
        add(8'($urandom_range(MAX_LEN + 1, 255)), rand_gap());
      end else begin
        len_v = (kind == 8) ? int'($urandom_range(1, MAX_LEN)) : int'($urandom_range(0, MAX_LEN));
        fb.delete();
        fb.push_back(SYNC);
        fb.push_back(8'(len_v));
        sum = 8'(len_v);
        for (int j = 0; j < len_v; j++) begin
          fb.push_back(8'($urandom_range(0, 255)));
          sum = sum + fb[j + 2];
        end
        cs = ~sum + 8'd1;
        if (kind == 5) cs = cs ^ 8'($urandom_range(1, 255));
        fb.push_back(cs);
        cut = (kind == 8) ? int'($urandom_range(1, fb.size() - 1)) : fb.size();
        for (int j = 0; j < cut; j++) add(fb[j], (j == 0) ? g0 : rand_gap());
        if (kind == 8) force_gap = 1'b1;
      end
    end
  endtask

  task automatic add_list(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                          input int count);
    logic [7:0] tmp [6];
    tmp = '{b0, b1, b2, b3, b4, b5};
    for (int j = 0; j < count; j++) add(tmp[j], 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int         n;
    logic [7:0] sum;
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'd0;
    out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", {out_last, out_data}, 0);
    check("rst_pulses", {frame_ok, err_csum, err_len, err_timeout, err_overrun}, 0);
    check("rst_state", dbg_state, HUNT);

    // Good frame with a permanently ready sink: three back-to-back transfers.
    ready_mode = 1;
    acc_cyc.delete();
    add_list(8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97, 6);
    run_stream();
    check("good_count", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) check("good_consecutive", acc_cyc[2] - acc_cyc[0], 2);
    check("good_busy_after", busy, 0);

    // Bad checksum then a good frame.
    add_list(8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98, 6);
    add_list(8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97, 6);
    run_stream();

    // Length limits: too long, zero length, and a full-size frame.
    add_list(8'hA5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    add_list(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3);
    add(SYNC, 0);
    add(8'(MAX_LEN), 0);
    sum = 8'(MAX_LEN);
    for (int j = 0; j < MAX_LEN; j++) begin
      add(8'($urandom_range(0, 255)), 0);
      sum = sum + s_b[s_b.size() - 1];
    end
    add(~sum + 8'd1, 0);
    run_stream();

    // Noise ahead of a frame.
    add_list(8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'hAA, 6);
    add_list(8'h55, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    run_stream();

    // Bytes landing exactly on the last allowed idle cycle keep the frame alive.
    add(8'hA5, 0); add(8'h02, 0); add(8'h11, T - 1); add(8'h22, T - 1); add(8'hCB, T - 1);
    run_stream();

    // Timeout latency measured from the last byte strobe.
    exp_ev.push_back(EV_TMO);
    send(8'hA5);
    send(8'h02);
    @(posedge clk); #1;
    byte_valid = 1'b1;
    byte_in    = 8'h11;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    n = 0;
    for (int k = 1; k <= 2 * T; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (err_timeout) begin
        n = k;
        break;
      end
    end
    check("timeout_latency", n, T);
    check("timeout_state", dbg_state, HUNT);
    repeat (4) @(posedge clk);
    check("timeout_events_left", exp_ev.size(), 0);

    // Backpressure with an overrun byte during the drain.
    ready_mode = 2;
    exp_ev.push_back(EV_OK);
    exp_ev.push_back(EV_OVR);
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    @(posedge clk); #1;
    byte_valid = 1'b1;
    byte_in    = 8'h97;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    @(negedge clk);
    check("ovr_valid_rise", out_valid, 1);
    check("ovr_frame_ok", frame_ok, 1);
    repeat (4) @(posedge clk);
    send(8'hA5);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("ovr_data_held", {out_valid, out_last, out_data}, {1'b1, 1'b0, 8'h11});
    check("ovr_state", dbg_state, DRAIN);
    ready_mode = 1;
    n = 0;
    while (out_valid && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ovr_state_after", dbg_state, HUNT);
    check("ovr_busy_after", busy, 0);
    check("ovr_data_left", exp_q.size(), 0);
    check("ovr_events_left", exp_ev.size(), 0);
    exp_q.delete();
    exp_ev.delete();

    // Reset in the middle of a payload.
    send(8'hA5); send(8'h03); send(8'h11);
    pulse_reset();
    @(negedge clk);
    check("rstp_outputs", {out_valid, out_last, out_data, busy}, 0);
    check("rstp_pulses", {frame_ok, err_csum, err_len, err_timeout, err_overrun}, 0);
    repeat (T + 4) @(posedge clk);
    add_list(8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97, 6);
    run_stream();

    // Reset in the middle of a drain.
    ready_mode = 2;
    exp_ev.push_back(EV_OK);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
    repeat (3) @(posedge clk);
    pulse_reset();
    ready_mode = 1;
    @(negedge clk);
    check("rstd_outputs", {out_valid, out_last, out_data, busy}, 0);
    check("rstd_pulses", {frame_ok, err_csum, err_len, err_timeout, err_overrun}, 0);
    check("rstd_events_left", exp_ev.size(), 0);
    repeat (T + 4) @(posedge clk);
    add_list(8'hA5, 8'h02, 8'hAA, 8'h55, 8'hFF, 8'h00, 5);
    run_stream();

    // Randomized streams with a randomly stalling sink.
    ready_mode = 0;
    repeat (3) begin
      gen_random(25);
      run_stream();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
